// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcode constants, access-size and DM FSM enums,
// and the memory-opcode decoder used by the DM stage.
package pipeline_pkg;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SB  = 6'h28;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_e;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_LD_WAIT,
        DM_RMW
    } dm_state_e;

    typedef struct packed {
        logic         is_load;
        logic         is_store;
        access_size_e size;
        logic         is_signed;
    } mem_op_t;

    function automatic mem_op_t decode_mem_op(input logic [5:0] opcode);
        mem_op_t op;
        op = '{is_load: 1'b0, is_store: 1'b0, size: SZ_WORD, is_signed: 1'b0};
        case (opcode)
            OP_LW:   begin op.is_load = 1'b1;  op.size = SZ_WORD; end
            OP_LH:   begin op.is_load = 1'b1;  op.size = SZ_HALF; op.is_signed = 1'b1; end
            OP_LHU:  begin op.is_load = 1'b1;  op.size = SZ_HALF; end
            OP_LB:   begin op.is_load = 1'b1;  op.size = SZ_BYTE; op.is_signed = 1'b1; end
            OP_LBU:  begin op.is_load = 1'b1;  op.size = SZ_BYTE; end
            OP_SW:   begin op.is_store = 1'b1; op.size = SZ_WORD; end
            OP_SH:   begin op.is_store = 1'b1; op.size = SZ_HALF; end
            OP_SB:   begin op.is_store = 1'b1; op.size = SZ_BYTE; end
            default: op.size = SZ_WORD;
        endcase
        return op;
    endfunction

    function automatic logic [2:0] size_bytes(input access_size_e size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Big-endian lane handling: extracts and extends a byte/halfword from a word,
// and merges new store data into the addressed lane of an old word.
module dm_lane_align
    import pipeline_pkg::*;
(
    input  logic [31:0]  word,
    input  logic [1:0]   offset,
    input  access_size_e size,
    input  logic         is_signed,
    input  logic [31:0]  new_data,
    output logic [31:0]  ext_data,
    output logic [31:0]  merged
);

    logic [4:0]  shamt;
    logic [31:0] aligned;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;

    // Offset 0 is the most significant lane, so shifting left brings the lane to the top.
    assign shamt   = {offset, 3'b000};
    assign aligned = word << shamt;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        ext_data  = word;
        lane_mask = '1;
        lane_data = new_data;
        case (size)
            SZ_BYTE: begin
                ext_data  = {{24{is_signed & aligned[31]}}, aligned[31:24]};
                lane_mask = 32'hFF00_0000 >> shamt;
                lane_data = {new_data[7:0], 24'h00_0000} >> shamt;
            end
            SZ_HALF: begin
                ext_data  = {{16{is_signed & aligned[31]}}, aligned[31:16]};
                lane_mask = 32'hFFFF_0000 >> shamt;
                lane_data = {new_data[15:0], 16'h0000} >> shamt;
            end
            default: begin
                ext_data  = word;
                lane_mask = '1;
                lane_data = new_data;
            end
        endcase
        merged = (word & ~lane_mask) | (lane_data & lane_mask);
    end

endmodule

// File: rtl/dm_stage.sv
// Data-memory pipeline stage: word-wide memory access with big-endian lane
// extraction, read-modify-write for SH/SB, error flagging and a registered WB result.
module dm_stage
    import pipeline_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_ins,
    input  logic [31:0]                    in_addr,
    input  logic [31:0]                    in_wdata,
    input  logic [4:0]                     in_rd,
    input  logic                           in_we,
    output logic [$clog2(DEPTH_WORDS)-1:0] RAddr_d,
    input  logic [31:0]                    Rdata_d,
    output logic                           Wen,
    output logic [$clog2(DEPTH_WORDS)-1:0] WAddr_d,
    output logic [31:0]                    Wdata_d,
    output logic                           wb_valid,
    output logic [31:0]                    wb_ins,
    output logic [31:0]                    wb_data,
    output logic [4:0]                     wb_rd,
    output logic                           wb_we,
    output logic                           err_misalign,
    output logic                           err_range
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] MAX_BYTE = 33'(4 * DEPTH_WORDS - 1);

    dm_state_e    state, state_nxt;
    mem_op_t      in_op;
    logic         accept, is_mem, mis, rng, err_any;
    logic [32:0]  last_byte;
    logic [AW-1:0] mem_addr;

    logic [31:0]   h_ins;
    logic [4:0]    h_rd;
    logic          h_we;
    logic [AW+1:0] h_addr;
    logic [31:0]   h_wdata;
    access_size_e  h_size;
    logic          h_signed;

    logic [31:0]   ext_data, merged;

    assign in_op     = decode_mem_op(in_ins[31:26]);
    assign in_ready  = (state == DM_IDLE);
    assign accept    = in_valid && in_ready;
    assign is_mem    = in_op.is_load || in_op.is_store;
    // Widened to 33 bits so an address near 2^32 reports out-of-range instead of wrapping.
    assign last_byte = {1'b0, in_addr} + 33'(size_bytes(in_op.size)) - 33'd1;
    assign mis       = is_mem && ((in_op.size == SZ_WORD && in_addr[1:0] != 2'b00) ||
                                  (in_op.size == SZ_HALF && in_addr[0]));
    assign rng       = is_mem && (last_byte > MAX_BYTE);
    assign err_any   = mis || rng;

    // Address ports are held at zero while reset is asserted.
    assign mem_addr = !rst ? '0 : (in_ready ? in_addr[AW+1:2] : h_addr[AW+1:2]);
    assign RAddr_d  = mem_addr;
    assign WAddr_d  = mem_addr;

    dm_lane_align u_align (
        .word      (Rdata_d),
        .offset    (h_addr[1:0]),
        .size      (h_size),
        .is_signed (h_signed),
        .new_data  (h_wdata),
        .ext_data  (ext_data),
        .merged    (merged)
    );

    always_comb begin
        state_nxt = state;
        Wen       = 1'b0;
        Wdata_d   = '0;
        case (state)
            DM_IDLE: begin
                if (accept && !err_any) begin
                    if (in_op.is_load) begin
                        state_nxt = DM_LD_WAIT;
                    end else if (in_op.is_store && in_op.size != SZ_WORD) begin
                        state_nxt = DM_RMW;
                    end else if (in_op.is_store) begin
                        Wen     = 1'b1;
                        Wdata_d = in_wdata;
                    end
                end
            end
            DM_LD_WAIT: state_nxt = DM_IDLE;
            DM_RMW: begin
                state_nxt = DM_IDLE;
                Wen       = 1'b1;
                Wdata_d   = merged;
            end
            default: state_nxt = DM_IDLE;
        endcase
        // Reset kills an in-flight write immediately, without waiting for a clock.
        if (!rst) begin
            Wen     = 1'b0;
            Wdata_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= DM_IDLE;
            wb_valid     <= 1'b0;
            wb_ins       <= '0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_we        <= 1'b0;
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
            h_ins        <= '0;
            h_rd         <= '0;
            h_we         <= 1'b0;
            h_addr       <= '0;
            h_wdata      <= '0;
            h_size       <= SZ_WORD;
            h_signed     <= 1'b0;
        end else begin
            state        <= state_nxt;
            wb_valid     <= 1'b0;
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
            case (state)
                DM_IDLE: begin
                    if (accept) begin
                        h_ins    <= in_ins;
                        h_rd     <= in_rd;
                        h_we     <= in_we;
                        h_addr   <= in_addr[AW+1:0];
                        h_wdata  <= in_wdata;
                        h_size   <= in_op.size;
                        h_signed <= in_op.is_signed;
                        if (state_nxt == DM_IDLE) begin
                            wb_valid     <= 1'b1;
                            wb_ins       <= in_ins;
                            wb_data      <= in_addr;
                            wb_rd        <= in_rd;
                            wb_we        <= in_we && !in_op.is_store && !err_any;
                            err_misalign <= mis;
                            err_range    <= rng;
                        end
                    end
                end
                DM_LD_WAIT: begin
                    wb_valid <= 1'b1;
                    wb_ins   <= h_ins;
                    wb_data  <= ext_data;
                    wb_rd    <= h_rd;
                    wb_we    <= h_we;
                end
                DM_RMW: begin
                    wb_valid <= 1'b1;
                    wb_ins   <= h_ins;
                    wb_data  <= merged;
                    wb_rd    <= h_rd;
                    wb_we    <= 1'b0;
                end
                default: wb_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: doc/dm_stage.md
# dm_stage

Data-memory (DM) stage of the MIPS-subset 5-stage pipeline, sitting between the EX/DM latch and the WB stage. It issues word-wide accesses to the external data memory (`RAddr_d`/`Rdata_d`/`Wen`/`WAddr_d`/`Wdata_d`) and handles big-endian byte and halfword lane extraction, sign/zero extension, and read-modify-write for SH/SB. It flags misaligned and out-of-range accesses, and presents a registered result to WB, including the instruction word used for the WB trace.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: data memory size in 32-bit words; word address width is 10 bits.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: EX/DM latch holds an instruction.
- `in_ready` out 1: stage accepts this cycle; high only in IDLE.
- `in_ins` in 32: instruction word; opcode is `[31:26]`.
- `in_addr` in 32: ALU result, either the effective byte address or the ALU value.
- `in_wdata` in 32: rt value for stores.
- `in_rd` in 5, `in_we` in 1: destination register and register write enable.
- `RAddr_d` out 10, `Rdata_d` in 32: synchronous-read memory port.
- `Wen` out 1, `WAddr_d` out 10, `Wdata_d` out 32: memory write port; the write takes effect at the edge.
- `wb_valid` out 1, `wb_ins` out 32, `wb_data` out 32, `wb_rd` out 5, `wb_we` out 1: registered result to WB.
- `err_misalign` out 1, `err_range` out 1: pulse together with the `wb_valid` of the offending instruction.

## Operation
- Opcode classes:
  - Loads: LW 0x23, LH 0x21, LHU 0x25, LB 0x20, LBU 0x24.
  - Stores: SW 0x2b, SH 0x29, SB 0x28.
  - Anything else is pass-through.
- Byte order is big-endian: byte offset 0 is bits `[31:24]`, halfword offset 0 is bits `[31:16]`.
- Error checks on accept:
  - Misalign: word access with `addr[1:0]≠0`, or halfword access with `addr[0]≠0`.
  - Range: `addr+size-1 > 4*DEPTH_WORDS-1`, compared at 33 bits with no wrap.
  - Both flags may be set together.
  - On any error, the access is suppressed (no `Wen`, no wait state), `wb_we=0`, and the instruction retires in 1 cycle.
- FSM states: IDLE, LD_WAIT, RMW.
  - IDLE + accepted load → LD_WAIT.
  - IDLE + accepted SH/SB → RMW.
  - LD_WAIT → IDLE: register the extracted and extended data into `wb_data`.
  - RMW → IDLE: `Wen=1`, `Wdata_d` = `Rdata_d` with the target lane replaced by `in_wdata`'s low byte or halfword.
  - IDLE + SW: `Wen=1` in the accept cycle with `Wdata_d=in_wdata`.
  - IDLE + pass-through: `wb_data=in_addr`.
- Address driving:
  - `RAddr_d` is driven from `in_addr[11:2]` in IDLE and from the held address otherwise.
  - `WAddr_d` is driven from the same source as `RAddr_d`.
- The instruction fields (ins, rd, we, addr, wdata, size/sign) are held internally while the stage is busy.
- WB outputs:
  - `wb_we` = held `in_we`; forced to 0 for stores and for errored loads.
  - `wb_ins` = accepted `in_ins`.

## Timing
- Reset (async, `rst=0`): state IDLE. `wb_*`, `err_*`, `Wen`, `RAddr_d`, `WAddr_d` and `Wdata_d` are all 0 (the address ports are forced to 0 during reset); `in_ready=1`.
- `Wen` is combinational from state/accept, so a reset asserted in RMW drops `Wen` immediately and memory is left unchanged.
- Memory read latency: `Rdata_d` is valid in the cycle after `RAddr_d` is sampled.
- Latency from the accept edge to `wb_valid`:
  - Pass-through, SW and any errored access: 1 edge; throughput 1 per cycle.
  - Loads, SH and SB: 2 edges; `in_ready` is low for exactly 1 cycle.
- `wb_valid` is a single-cycle pulse per instruction. It is 0 when nothing was accepted in the prior cycle and no FSM state completed.
- Back-to-back: accept is permitted in the same cycle the FSM returns to IDLE.

## Structure
- Shared package `pipeline_pkg` holds:
  - opcode constants (shared with decode/trace),
  - the access-size enum (BYTE/HALF/WORD),
  - the dm FSM state enum.
- One combinational sub-module, `dm_lane_align`, does both directions:
  - extract + sign/zero extend, given word, offset, size and signedness;
  - merge, given old word, new data, offset and size.

## Test plan
Preload word 0x004 = 0x8899AABB.
- LB 0x011 → `RAddr_d`=0x004; `wb_data`=0xFFFFFF99 after 2 edges; `in_ready` low 1 cycle.
- LHU 0x012 → 0x0000AABB; LH 0x012 → 0xFFFFAABB; LBU 0x010 → 0x00000088.
- SB 0x013, `in_wdata` 0x12345677 → second cycle `Wen=1`, `WAddr_d`=0x004, `Wdata_d`=0x8899AA77; `wb_we=0`.
- LW 0x002 → `err_misalign=1`, no LD_WAIT, `wb_we=0`. SW 0x1000 → `err_range=1`, `Wen` never asserted.
- Reset pulled low during the RMW cycle of SH 0x010 → `Wen` drops immediately; word 0x004 stays 0x8899AABB; all outputs 0; `in_ready=1`.
- ADD, ADD, SW 0x020 with `in_valid` held high → three consecutive `wb_valid` pulses; `Wen` asserted in the third accept cycle.
